// File: rtl/fir_pkg.sv
// Shared FIR helpers: width math and the round/saturate step used by the
// filter top (and later decimator variants).
package fir_pkg;
  localparam int ACC_MAX = 96;  // working width for round/saturate; must exceed WIDTH_ACC

  typedef logic signed [ACC_MAX-1:0] wide_t;

  typedef struct packed {
    wide_t val;
    logic  sat;
  } rs_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int prod_w(input int wx, input int wc);
    return wx + wc;
  endfunction

  localparam int PROD_W_DEF = prod_w(18, 18);

  // Round half up at bit SHIFT, then clip to a signed wout-bit range.
  function automatic rs_t round_sat(input wide_t acc, input int shift, input int wout);
    wide_t r, hi;
    rs_t   o;
    r = acc;
    if (shift > 0) r = r + (wide_t'(1) <<< (shift - 1));
    r = r >>> shift;
    hi = (wide_t'(1) <<< (wout - 1)) - wide_t'(1);
    o.val = r;
    o.sat = 1'b0;
    if (r > hi) begin
      o.val = hi;
      o.sat = 1'b1;
    end else if (r < ~hi) begin
      o.val = ~hi;
      o.sat = 1'b1;
    end
    return o;
  endfunction
endpackage

// File: rtl/fir_tap.sv
// One transposed-form tap: shadow/active coefficient pair and its partial-sum register.
module fir_tap import fir_pkg::*; #(
  parameter int WIDTH_X   = 18,
  parameter int WIDTH_C   = 18,
  parameter int WIDTH_ACC = 48
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ena,
  input  logic                        clear,
  input  logic                        upd,
  input  logic                        commit,
  input  logic                        wr,
  input  logic signed [WIDTH_C-1:0]   coef_data,
  input  logic signed [WIDTH_X-1:0]   x_reg,
  input  logic        [WIDTH_ACC-1:0] z_in,
  output logic        [WIDTH_ACC-1:0] z
);
  localparam int PW = prod_w(WIDTH_X, WIDTH_C);

  logic signed [WIDTH_C-1:0]   shadow, active;
  logic signed [PW-1:0]        prod;
  logic        [WIDTH_ACC-1:0] prod_ext;

  assign prod     = x_reg * active;
  assign prod_ext = {{(WIDTH_ACC-PW){prod[PW-1]}}, prod};

  // Commit reads shadow before this edge's write, and the update reads
  // active before this edge's commit: both fall out of non-blocking order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow <= '0;
      active <= '0;
      z      <= '0;
    end else if (ena) begin
      if (wr)     shadow <= coef_data;
      if (commit) active <= shadow;
      if (clear)    z <= '0;
      else if (upd) z <= prod_ext + z_in;
    end
  end
endmodule

// File: rtl/fir_transposed_cfg.sv
// Transposed-form FIR with run-time coefficient bank, bubble-tolerant valid
// stream, delay-line clear and round/saturate to WIDTH_OUT.
module fir_transposed_cfg import fir_pkg::*; #(
  parameter int NTAPS     = 8,
  parameter int WIDTH_X   = 18,
  parameter int WIDTH_C   = 18,
  parameter int WIDTH_ACC = 48,
  parameter int WIDTH_OUT = 18,
  parameter int SHIFT     = 17
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ena,
  input  logic                        in_valid,
  input  logic signed [WIDTH_X-1:0]   x_in,
  input  logic                        clear,
  input  logic                        coef_wr,
  input  logic [clog2(NTAPS)-1:0]     coef_addr,
  input  logic signed [WIDTH_C-1:0]   coef_data,
  input  logic                        coef_commit,
  output logic                        out_valid,
  output logic signed [WIDTH_OUT-1:0] y_out,
  output logic                        sat
);
  localparam int AW     = clog2(NTAPS);
  localparam int STAGES = 3;

  logic signed [WIDTH_X-1:0]         x_reg;
  logic [STAGES-1:0]                 vld_pipe;  // [0]=v1, [1]=v2, [2]=out_valid
  logic [NTAPS:0][WIDTH_ACC-1:0]     zc;
  wide_t                             z0w;
  rs_t                               rs;
  logic                              unused_hi;

  assign zc[NTAPS] = '0;

  for (genvar k = 0; k < NTAPS; k++) begin : g_tap
    fir_tap #(
      .WIDTH_X  (WIDTH_X),
      .WIDTH_C  (WIDTH_C),
      .WIDTH_ACC(WIDTH_ACC)
    ) u_tap (
      .clk      (clk),
      .rst      (rst),
      .ena      (ena),
      .clear    (clear),
      .upd      (vld_pipe[0]),
      .commit   (coef_commit),
      .wr       (coef_wr && (coef_addr == AW'(k))),
      .coef_data(coef_data),
      .x_reg    (x_reg),
      .z_in     (zc[k+1]),
      .z        (zc[k])
    );
  end

  assign z0w       = {{(ACC_MAX-WIDTH_ACC){zc[0][WIDTH_ACC-1]}}, zc[0]};
  assign rs        = round_sat(z0w, SHIFT, WIDTH_OUT);
  assign unused_hi = ^rs.val[ACC_MAX-1:WIDTH_OUT];
  assign out_valid = vld_pipe[STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      x_reg    <= '0;
      vld_pipe <= '0;
      y_out    <= '0;
      sat      <= 1'b0;
    end else if (ena) begin
      if (clear) begin
        x_reg    <= '0;
        vld_pipe <= '0;
      end else begin
        x_reg    <= x_in;
        vld_pipe <= {vld_pipe[STAGES-2:0], in_valid};
        if (vld_pipe[1]) begin
          y_out <= rs.val[WIDTH_OUT-1:0];
          sat   <= rs.sat;
        end
      end
    end
  end
endmodule
